// File: rtl/cd_drive_scheduler.sv
// Playback scheduler for a CD-style sector cache: paces sectors at 1x/2x rate,
// sequences PLAY/PAUSE/RESUME/STOP and counts missed sector intervals.
module cd_drive_scheduler #(
    parameter int unsigned CLK_FREQ    = 30000000,
    parameter int unsigned SECTOR_RATE = 75
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_lba,
    input  logic        double_speed,
    output logic [31:0] seek_lba,
    output logic        seek_lba_valid,
    output logic        sector_tick,
    input  logic        sector_delivered,
    output logic        stop_sector_delivery,
    output logic [31:0] cur_lba,
    output logic [1:0]  state,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned DIV = CLK_FREQ / SECTOR_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM_1X = CW'(DIV - 1);
    localparam logic [CW-1:0] TERM_2X = CW'(DIV / 2 - 1);

    localparam logic [1:0] OP_STOP   = 2'd0;
    localparam logic [1:0] OP_PLAY   = 2'd1;
    localparam logic [1:0] OP_PAUSE  = 2'd2;
    localparam logic [1:0] OP_RESUME = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSeek    = 2'd1,
        StPlaying = 2'd2,
        StPaused  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, term_q, term_d;
    logic          tick_q, tick_d;
    logic [31:0]   seek_lba_q, seek_lba_d, cur_lba_q, cur_lba_d;
    logic          seek_valid_q, seek_valid_d, stop_q, stop_d;
    logic [7:0]    underrun_q, underrun_d;
    logic          armed_q, armed_d, dflag_q, dflag_d, ready_q, ready_d;

    logic          accept, playing, deliv_now, cmd_hit, go_seek;
    logic [31:0]   go_lba;

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        term_d       = term_q;
        tick_d       = 1'b0;
        state_d      = state_q;
        seek_lba_d   = seek_lba_q;
        cur_lba_d    = cur_lba_q;
        seek_valid_d = 1'b0;
        stop_d       = 1'b0;
        underrun_d   = underrun_q;
        armed_d      = armed_q;
        dflag_d      = dflag_q;
        cmd_hit      = 1'b0;
        go_seek      = 1'b0;
        go_lba       = 32'd0;

        accept    = cmd_valid && ready_q;
        playing   = (state_q == StPlaying);
        deliv_now = sector_delivered && playing;

        // Period length is latched at wrap so a speed change never cuts a period short.
        if (cnt_q == term_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            term_d = double_speed ? TERM_2X : TERM_1X;
        end

        // A delivery in the tick cycle belongs to the interval that tick closes.
        if (tick_q) begin
            if (playing && armed_q && !(dflag_q || deliv_now) && underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
            end
            dflag_d = 1'b0;
        end else if (deliv_now) begin
            dflag_d = 1'b1;
        end
        if (deliv_now) begin
            armed_d = 1'b1;
        end

        if (state_q == StSeek) begin
            state_d = StPlaying;
        end

        if (accept) begin
            unique case (cmd_op)
                OP_PLAY: begin
                    go_seek = 1'b1;
                    go_lba  = cmd_lba;
                end
                OP_RESUME: begin
                    if (state_q == StPaused) begin
                        go_seek = 1'b1;
                        go_lba  = cur_lba_q;
                    end
                end
                OP_PAUSE: begin
                    if (playing) begin
                        cmd_hit = 1'b1;
                        state_d = StPaused;
                        stop_d  = 1'b1;
                    end
                end
                OP_STOP: begin
                    cmd_hit = 1'b1;
                    state_d = StIdle;
                    stop_d  = 1'b1;
                    armed_d = 1'b0;
                end
            endcase
        end

        if (go_seek) begin
            cmd_hit      = 1'b1;
            state_d      = StSeek;
            seek_lba_d   = go_lba;
            cur_lba_d    = go_lba;
            seek_valid_d = 1'b1;
            armed_d      = 1'b0;
            dflag_d      = 1'b0;
        end

        if (deliv_now && !cmd_hit) begin
            cur_lba_d = cur_lba_q + 32'd1;
        end

        ready_d = (state_d != StSeek);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            term_q       <= TERM_1X;
            tick_q       <= 1'b0;
            seek_lba_q   <= 32'd0;
            cur_lba_q    <= 32'd0;
            seek_valid_q <= 1'b0;
            stop_q       <= 1'b0;
            underrun_q   <= 8'd0;
            armed_q      <= 1'b0;
            dflag_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            term_q       <= term_d;
            tick_q       <= tick_d;
            seek_lba_q   <= seek_lba_d;
            cur_lba_q    <= cur_lba_d;
            seek_valid_q <= seek_valid_d;
            stop_q       <= stop_d;
            underrun_q   <= underrun_d;
            armed_q      <= armed_d;
            dflag_q      <= dflag_d;
            ready_q      <= ready_d;
        end
    end

    assign cmd_ready            = ready_q;
    assign seek_lba             = seek_lba_q;
    assign seek_lba_valid       = seek_valid_q;
    assign sector_tick          = tick_q;
    assign stop_sector_delivery = stop_q;
    assign cur_lba              = cur_lba_q;
    assign state                = state_q;
    assign underrun_cnt         = underrun_q;

endmodule
